channel_mixer: RTL and testbench
================================

# channel_mixer

Parametrised, time-multiplexed successor to the four-channel shifter/adder. Mixes NUM_CH signed voice channels into one signed SAMPLE_W output once per audio sample tick. Adds what the fixed mixer lacks: per-channel gain, click-free attack/release ramps on key-on/off, saturating output, and a strobe/valid handshake. Sits between the per-channel wave generators and the DAC/PWM output stage.

## Interface
- NUM_CH, 4, number of channels (≥2, power of two)
- SAMPLE_W, 8, channel and output sample width (signed two's complement)
- FREQ_W, 12, per-channel frequency word width; value 0 means channel silent
- GAIN_W, 4, per-channel unsigned gain and ramp width
- OUT_SHIFT, GAIN_W+log2(NUM_CH), arithmetic right shift applied to the accumulator before saturation
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- sample_tick  in  1  one-cycle strobe: chl_in/freq_in/gain_in valid this cycle
- chl_in  in  NUM_CH*SAMPLE_W  channel samples, ch i at [i*SAMPLE_W +: SAMPLE_W]
- freq_in  in  NUM_CH*FREQ_W  channel frequency words, same packing
- gain_in  in  NUM_CH*GAIN_W  unsigned channel gains, same packing
- sound_out  out  SAMPLE_W  mixed signed sample, held between updates
- sound_valid  out  1  one-cycle pulse when sound_out updates
- busy  out  1  high while a mix is in progress (ACCUM or OUTPUT)
- overrun  out  1  sticky: a sample_tick arrived while busy; cleared only by reset

## Operation
- States: IDLE, ACCUM, OUTPUT.
- IDLE: on sample_tick, snapshot chl_in, gain_in, and per-channel active bit (freq_in slice != 0); update ramps; clear accumulator; channel index := 0; go ACCUM.
- Ramp r[i] (GAIN_W bits, 0..2^GAIN_W−1), updated on each accepted tick only: active and r<max → r+1; inactive and r>0 → r−1; otherwise unchanged.
- Weight w[i] = min(gain[i], r[i]) using the post-update ramp. Inactive channel with r>0 still contributes (release tail).
- ACCUM: one channel per cycle, index 0..NUM_CH−1: acc += signed(sample[i]) * w[i]. Product is signed SAMPLE_W+GAIN_W+1 bits; accumulator is SAMPLE_W+GAIN_W+log2(NUM_CH)+1 bits, never wraps. After the last channel go OUTPUT.
- OUTPUT: mix = acc >>> OUT_SHIFT (arithmetic); clamp to [−2^(SAMPLE_W−1), 2^(SAMPLE_W−1)−1]; register to sound_out; pulse sound_valid; go IDLE.
- sample_tick while busy: ignored (no snapshot, no ramp update), overrun := 1. In-flight mix completes unaffected.
- Inputs read only on the accepting cycle; later changes do not affect the in-flight mix.

## Timing
- Tick accepted at cycle T (state IDLE). ACCUM cycles T+1..T+NUM_CH. OUTPUT at T+NUM_CH+1: sound_out and sound_valid visible after that edge. Latency NUM_CH+1 cycles; minimum tick spacing NUM_CH+2 cycles.
- busy high from the cycle after acceptance through the OUTPUT cycle; low in IDLE.
- Tick on the same cycle OUTPUT returns to IDLE is rejected (counted as overrun); the first cycle back in IDLE accepts.
- Reset values: sound_out 0, sound_valid 0, busy 0, overrun 0, all r[i] 0, accumulator 0, state IDLE.
- Reset asserted mid-ACCUM/OUTPUT: mix aborted, no sound_valid, all state to reset values on that edge.

## Test plan
- Key-on ramp: ch0 sample 0x40, freq 100, gain 15; others freq 0; 17 ticks spaced 8 cycles → sound_out 1,2,…,15,15,15 (0x40·k>>>6), one sound_valid per tick, 5 cycles after each tick.
- Key-off release: continue previous with ch0 freq 0 → outputs 14,13,…,1,0, then 0 held; ramp stays 0.
- Full-scale negative: all four channels 0x80, gain 15, ramps saturated → acc −7680, sound_out 0x88 (−120); no clamp.
- Saturation with OUT_SHIFT=4: all channels 0x7F, gain 15, ramps full → 476 clamps to 0x7F; all 0x80 → −480 clamps to 0x80.
- Overrun: second tick 2 cycles after first → exactly one sound_valid, value from first snapshot, overrun=1 and sticky until rst_n low; ramps advanced once.
- Reset mid-ACCUM: rst_n low at T+2 for one cycle → no sound_valid, sound_out 0, busy 0, overrun 0; next tick restarts ramps from 1.

Source files
------------

// File: rtl/channel_mixer.sv
// channel_mixer: time-multiplexed NUM_CH-voice mixer with per-channel gain,
// attack/release ramps, saturating output and a strobe/valid handshake.
module channel_mixer #(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned SAMPLE_W  = 8,
  parameter int unsigned FREQ_W    = 12,
  parameter int unsigned GAIN_W    = 4,
  parameter int unsigned OUT_SHIFT = GAIN_W + $clog2(NUM_CH)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       sample_tick,
  input  logic [NUM_CH*SAMPLE_W-1:0] chl_in,
  input  logic [NUM_CH*FREQ_W-1:0]   freq_in,
  input  logic [NUM_CH*GAIN_W-1:0]   gain_in,
  output logic [SAMPLE_W-1:0]        sound_out,
  output logic                       sound_valid,
  output logic                       busy,
  output logic                       overrun
);

  localparam int unsigned IDX_W  = $clog2(NUM_CH);
  localparam int unsigned PROD_W = SAMPLE_W + GAIN_W + 1;
  localparam int unsigned ACC_W  = SAMPLE_W + GAIN_W + IDX_W + 1;

  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W - SAMPLE_W + 1){1'b0}}, {(SAMPLE_W - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_OUTPUT
  } state_e;

  state_e                     state_q, state_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic signed [SAMPLE_W-1:0] smp_q  [NUM_CH];
  logic signed [SAMPLE_W-1:0] smp_d  [NUM_CH];
  logic [GAIN_W-1:0]          wgt_q  [NUM_CH];
  logic [GAIN_W-1:0]          wgt_d  [NUM_CH];
  logic [GAIN_W-1:0]          ramp_q [NUM_CH];
  logic [GAIN_W-1:0]          ramp_d [NUM_CH];
  logic [SAMPLE_W-1:0]        sound_out_q, sound_out_d;
  logic                       sound_valid_q, sound_valid_d;
  logic                       busy_q, busy_d;
  logic                       overrun_q, overrun_d;

  logic [GAIN_W-1:0]          gain_c;
  logic                       active_c;
  logic signed [PROD_W-1:0]   smp_ext_c;
  logic signed [PROD_W-1:0]   wgt_ext_c;
  logic signed [PROD_W-1:0]   prod_c;
  logic signed [ACC_W-1:0]    mix_c;
  logic signed [ACC_W-1:0]    sat_c;

  // Shared multiplier for the channel selected by idx_q, plus the output clamp.
  always_comb begin
    smp_ext_c = PROD_W'(smp_q[idx_q]);
    wgt_ext_c = PROD_W'($signed({1'b0, wgt_q[idx_q]}));
    prod_c    = smp_ext_c * wgt_ext_c;
    mix_c     = acc_q >>> OUT_SHIFT;
    if (mix_c > SAT_MAX) begin
      sat_c = SAT_MAX;
    end else if (mix_c < SAT_MIN) begin
      sat_c = SAT_MIN;
    end else begin
      sat_c = mix_c;
    end
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    acc_d         = acc_q;
    smp_d         = smp_q;
    wgt_d         = wgt_q;
    ramp_d        = ramp_q;
    sound_out_d   = sound_out_q;
    sound_valid_d = 1'b0;
    overrun_d     = overrun_q;
    gain_c        = '0;
    active_c      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (sample_tick) begin
          // Snapshot inputs and fold the post-update ramp into a single weight.
          for (int i = 0; i < NUM_CH; i++) begin
            smp_d[i] = chl_in[i*SAMPLE_W +: SAMPLE_W];
            gain_c   = gain_in[i*GAIN_W +: GAIN_W];
            active_c = |freq_in[i*FREQ_W +: FREQ_W];
            if (active_c && (ramp_q[i] != '1)) begin
              ramp_d[i] = ramp_q[i] + 1'b1;
            end else if (!active_c && (ramp_q[i] != '0)) begin
              ramp_d[i] = ramp_q[i] - 1'b1;
            end
            wgt_d[i] = (gain_c < ramp_d[i]) ? gain_c : ramp_d[i];
          end
          acc_d   = '0;
          idx_d   = '0;
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        acc_d = acc_q + ACC_W'(prod_c);
        idx_d = IDX_W'(idx_q + 1'b1);
        if (idx_q == IDX_W'(NUM_CH - 1)) begin
          state_d = S_OUTPUT;
        end
      end
      S_OUTPUT: begin
        sound_out_d   = SAMPLE_W'(sat_c);
        sound_valid_d = 1'b1;
        state_d       = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A tick that lands while a mix is in flight is dropped and flagged.
    if (sample_tick && (state_q != S_IDLE)) begin
      overrun_d = 1'b1;
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      acc_q         <= '0;
      sound_out_q   <= '0;
      sound_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      overrun_q     <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        smp_q[i]  <= '0;
        wgt_q[i]  <= '0;
        ramp_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      acc_q         <= acc_d;
      smp_q         <= smp_d;
      wgt_q         <= wgt_d;
      ramp_q        <= ramp_d;
      sound_out_q   <= sound_out_d;
      sound_valid_q <= sound_valid_d;
      busy_q        <= busy_d;
      overrun_q     <= overrun_d;
    end
  end

  assign sound_out   = sound_out_q;
  assign sound_valid = sound_valid_q;
  assign busy        = busy_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_channel_mixer.sv
// Self-checking bench for channel_mixer: default instance plus an OUT_SHIFT=4
// instance sharing the same stimulus, both checked against a ramp/gain model.
module tb_channel_mixer;

  localparam int unsigned NCH = 4;
  localparam int unsigned SW  = 8;
  localparam int unsigned FW  = 12;
  localparam int unsigned GW  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              sample_tick;
  logic [NCH*SW-1:0] chl_in;
  logic [NCH*FW-1:0] freq_in;
  logic [NCH*GW-1:0] gain_in;
  logic [SW-1:0]     sound_out, sound_out_s;
  logic              sound_valid, sound_valid_s;
  logic              busy, busy_s;
  logic              overrun, overrun_s;

  int total = 0;
  int bad   = 0;
  int ramp_m [NCH];

  always #5 clk = ~clk;

  channel_mixer dut (
    .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick),
    .chl_in(chl_in), .freq_in(freq_in), .gain_in(gain_in),
    .sound_out(sound_out), .sound_valid(sound_valid),
    .busy(busy), .overrun(overrun)
  );

  channel_mixer #(.OUT_SHIFT(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick),
    .chl_in(chl_in), .freq_in(freq_in), .gain_in(gain_in),
    .sound_out(sound_out_s), .sound_valid(sound_valid_s),
    .busy(busy_s), .overrun(overrun_s)
  );

  function automatic int clamp8(input int v);
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) ramp_m[i] = 0;
  endtask

  // Reference: ramp step, weight = min(gain, ramp), plain integer mix.
  task automatic model_tick(input logic [31:0] chl, input logic [47:0] freq,
                            input logic [15:0] gain,
                            output logic [7:0] e6, output logic [7:0] e4);
    int acc, s, g, w;
    acc = 0;
    for (int i = 0; i < NCH; i++) begin
      if (freq[i*FW +: FW] != 0) ramp_m[i] = (ramp_m[i] < 15) ? ramp_m[i] + 1 : 15;
      else                       ramp_m[i] = (ramp_m[i] > 0) ? ramp_m[i] - 1 : 0;
      s = $signed(chl[i*SW +: SW]);
      g = int'(gain[i*GW +: GW]);
      w = (g < ramp_m[i]) ? g : ramp_m[i];
      acc += s * w;
    end
    e6 = 8'(clamp8(acc >>> 6));
    e4 = 8'(clamp8(acc >>> 4));
  endtask

  // Issue one tick, scramble inputs afterwards, and observe for 8 cycles.
  task automatic do_mix(input logic [31:0] chl, input logic [47:0] freq,
                        input logic [15:0] gain,
                        output int lat, output int pulses,
                        output logic [7:0] o6, output logic [7:0] o4,
                        output logic b_run, output logic b_idle);
    @(negedge clk);
    sample_tick = 1'b1; chl_in = chl; freq_in = freq; gain_in = gain;
    lat = -1; pulses = 0; o6 = 'x; o4 = 'x; b_run = 1'b0; b_idle = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      sample_tick = 1'b0;
      chl_in  = $urandom;
      freq_in = 48'({$urandom, $urandom});
      gain_in = 16'($urandom);
      if (k == 0) b_run = busy;
      if (k == 5) b_idle = busy;
      if (sound_valid) begin
        pulses++;
        if (lat < 0) begin lat = k; o6 = sound_out; o4 = sound_out_s; end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sample_tick = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (sound_out !== 8'h00) begin bad++; $display("FAIL reset_sound_out got=%h want=00", sound_out); end
    total++; if (sound_out_s !== 8'h00) begin bad++; $display("FAIL reset_sound_out_s got=%h want=00", sound_out_s); end
    total++; if (sound_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", sound_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b want=0", overrun); end
    sample_tick = 1'b0; rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_key_on();
    logic [31:0] chl; logic [47:0] freq; logic [15:0] gain;
    logic [7:0] e6, e4, o6, o4; int lat, pulses; logic br, bi;
    for (int n = 0; n < 17; n++) begin
      chl = $urandom; chl[7:0] = 8'h40;
      gain = 16'($urandom); gain[3:0] = 4'hF;
      freq = 48'd100;
      model_tick(chl, freq, gain, e6, e4);
      do_mix(chl, freq, gain, lat, pulses, o6, o4, br, bi);
      total++; if (lat !== 5) begin bad++; $display("FAIL keyon_latency[%0d] got=%0d want=5", n, lat); end
      total++; if (pulses !== 1) begin bad++; $display("FAIL keyon_pulses[%0d] got=%0d want=1", n, pulses); end
      total++; if (o6 !== e6) begin bad++; $display("FAIL keyon_out[%0d] got=%h want=%h", n, o6, e6); end
      total++; if (o4 !== e4) begin bad++; $display("FAIL keyon_out_s[%0d] got=%h want=%h", n, o4, e4); end
      total++; if (br !== 1'b1) begin bad++; $display("FAIL keyon_busy_run[%0d] got=%b want=1", n, br); end
      total++; if (bi !== 1'b0) begin bad++; $display("FAIL keyon_busy_idle[%0d] got=%b want=0", n, bi); end
    end
  endtask

  task automatic test_release();
    logic [31:0] chl; logic [47:0] freq; logic [15:0] gain;
    logic [7:0] e6, e4, o6, o4; int lat, pulses; logic br, bi;
    for (int n = 0; n < 17; n++) begin
      chl = $urandom; chl[7:0] = 8'h40;
      gain = 16'($urandom); gain[3:0] = 4'hF;
      freq = '0;
      model_tick(chl, freq, gain, e6, e4);
      do_mix(chl, freq, gain, lat, pulses, o6, o4, br, bi);
      total++; if (lat !== 5) begin bad++; $display("FAIL release_latency[%0d] got=%0d want=5", n, lat); end
      total++; if (o6 !== e6) begin bad++; $display("FAIL release_out[%0d] got=%h want=%h", n, o6, e6); end
      total++; if (o4 !== e4) begin bad++; $display("FAIL release_out_s[%0d] got=%h want=%h", n, o4, e4); end
    end
  endtask

  task automatic test_full_scale();
    logic [31:0] chl; logic [47:0] freq; logic [15:0] gain;
    logic [7:0] e6, e4, o6, o4; int lat, pulses; logic br, bi;
    for (int n = 0; n < 17; n++) begin
      for (int i = 0; i < NCH; i++) freq[i*FW +: FW] = 12'($urandom_range(1, 4095));
      gain = 16'hFFFF;
      if (n == 15)      chl = 32'h80808080;
      else if (n == 16) chl = 32'h7F7F7F7F;
      else              chl = $urandom;
      model_tick(chl, freq, gain, e6, e4);
      do_mix(chl, freq, gain, lat, pulses, o6, o4, br, bi);
      total++; if (o6 !== e6) begin bad++; $display("FAIL fullscale_out[%0d] got=%h want=%h", n, o6, e6); end
      total++; if (o4 !== e4) begin bad++; $display("FAIL fullscale_out_s[%0d] got=%h want=%h", n, o4, e4); end
    end
  endtask

  task automatic test_random();
    logic [31:0] chl; logic [47:0] freq; logic [15:0] gain;
    logic [7:0] e6, e4, o6, o4; int lat, pulses; logic br, bi;
    for (int n = 0; n < 40; n++) begin
      chl = $urandom;
      gain = 16'($urandom);
      for (int i = 0; i < NCH; i++)
        freq[i*FW +: FW] = ($urandom_range(0, 9) < 3) ? 12'd0 : 12'($urandom_range(1, 4095));
      model_tick(chl, freq, gain, e6, e4);
      do_mix(chl, freq, gain, lat, pulses, o6, o4, br, bi);
      total++; if (lat !== 5) begin bad++; $display("FAIL random_latency[%0d] got=%0d want=5", n, lat); end
      total++; if (pulses !== 1) begin bad++; $display("FAIL random_pulses[%0d] got=%0d want=1", n, pulses); end
      total++; if (o6 !== e6) begin bad++; $display("FAIL random_out[%0d] got=%h want=%h", n, o6, e6); end
      total++; if (o4 !== e4) begin bad++; $display("FAIL random_out_s[%0d] got=%h want=%h", n, o4, e4); end
      total++; if (overrun !== 1'b0) begin bad++; $display("FAIL random_overrun[%0d] got=%b want=0", n, overrun); end
    end
  endtask

  task automatic test_overrun();
    logic [31:0] chl; logic [47:0] freq; logic [15:0] gain;
    logic [7:0] e6, e4, o6, o4; int lat, pulses; logic br, bi;
    chl = 32'h00000040; freq = 48'd100; gain = 16'h000F;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    model_reset();
    model_tick(chl, freq, gain, e6, e4);
    @(negedge clk);
    sample_tick = 1'b1; chl_in = chl; freq_in = freq; gain_in = gain;
    lat = -1; pulses = 0; o6 = 'x; o4 = 'x;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (sound_valid) begin
        pulses++;
        if (lat < 0) begin lat = k; o6 = sound_out; o4 = sound_out_s; end
      end
      sample_tick = (k == 1);
      chl_in  = (k == 1) ? 32'h7F7F7F7F : $urandom;
      freq_in = (k == 1) ? 48'h001001001001 : 48'({$urandom, $urandom});
      gain_in = (k == 1) ? 16'hFFFF : 16'($urandom);
    end
    total++; if (pulses !== 1) begin bad++; $display("FAIL overrun_pulses got=%0d want=1", pulses); end
    total++; if (lat !== 5) begin bad++; $display("FAIL overrun_latency got=%0d want=5", lat); end
    total++; if (o6 !== e6) begin bad++; $display("FAIL overrun_out got=%h want=%h", o6, e6); end
    total++; if (o4 !== e4) begin bad++; $display("FAIL overrun_out_s got=%h want=%h", o4, e4); end
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL overrun_flag got=%b want=1", overrun); end
    total++; if (overrun_s !== 1'b1) begin bad++; $display("FAIL overrun_flag_s got=%b want=1", overrun_s); end
    model_tick(chl, freq, gain, e6, e4);
    do_mix(chl, freq, gain, lat, pulses, o6, o4, br, bi);
    total++; if (o6 !== e6) begin bad++; $display("FAIL overrun_ramp_once got=%h want=%h", o6, e6); end
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL overrun_sticky got=%b want=1", overrun); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] chl; logic [47:0] freq; logic [15:0] gain;
    logic [7:0] ea6, ea4, ec6, ec4, v1, v2, v1s, v2s; int l1, l2, pulses;
    chl = 32'h00000040; freq = 48'd100; gain = 16'h000F;
    model_tick(chl, freq, gain, ea6, ea4);
    model_tick(chl, freq, gain, ec6, ec4);
    @(negedge clk);
    sample_tick = 1'b1; chl_in = chl; freq_in = freq; gain_in = gain;
    l1 = -1; l2 = -1; pulses = 0; v1 = 'x; v2 = 'x; v1s = 'x; v2s = 'x;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (sound_valid) begin
        pulses++;
        if (l1 < 0) begin l1 = k; v1 = sound_out; v1s = sound_out_s; end
        else if (l2 < 0) begin l2 = k; v2 = sound_out; v2s = sound_out_s; end
      end
      sample_tick = (k == 4) || (k == 5);
      if (k == 4) begin chl_in = 32'h7F7F7F7F; freq_in = 48'h001001001001; gain_in = 16'hFFFF; end
      else if (k == 5) begin chl_in = chl; freq_in = freq; gain_in = gain; end
      else begin chl_in = $urandom; freq_in = 48'({$urandom, $urandom}); gain_in = 16'($urandom); end
    end
    total++; if (pulses !== 2) begin bad++; $display("FAIL b2b_pulses got=%0d want=2", pulses); end
    total++; if (l1 !== 5) begin bad++; $display("FAIL b2b_latency_a got=%0d want=5", l1); end
    total++; if (l2 !== 11) begin bad++; $display("FAIL b2b_latency_c got=%0d want=11", l2); end
    total++; if (v1 !== ea6) begin bad++; $display("FAIL b2b_out_a got=%h want=%h", v1, ea6); end
    total++; if (v2 !== ec6) begin bad++; $display("FAIL b2b_out_c got=%h want=%h", v2, ec6); end
    total++; if (v1s !== ea4) begin bad++; $display("FAIL b2b_out_s_a got=%h want=%h", v1s, ea4); end
    total++; if (v2s !== ec4) begin bad++; $display("FAIL b2b_out_s_c got=%h want=%h", v2s, ec4); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] chl; logic [47:0] freq; logic [15:0] gain;
    logic [7:0] e6, e4, o6, o4; int lat, pulses; logic br, bi;
    chl = 32'h00000040; freq = 48'd100; gain = 16'h000F;
    @(negedge clk);
    sample_tick = 1'b1; chl_in = chl; freq_in = freq; gain_in = gain;
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (sound_valid || sound_valid_s) pulses++;
      sample_tick = 1'b0;
      if (k == 1) rst_n = 1'b0;
      if (k == 2) rst_n = 1'b1;
    end
    total++; if (pulses !== 0) begin bad++; $display("FAIL midreset_pulses got=%0d want=0", pulses); end
    total++; if (sound_out !== 8'h00) begin bad++; $display("FAIL midreset_sound_out got=%h want=00", sound_out); end
    total++; if (sound_out_s !== 8'h00) begin bad++; $display("FAIL midreset_sound_out_s got=%h want=00", sound_out_s); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midreset_busy got=%b want=0", busy); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL midreset_overrun got=%b want=0", overrun); end
    model_reset();
    model_tick(chl, freq, gain, e6, e4);
    do_mix(chl, freq, gain, lat, pulses, o6, o4, br, bi);
    total++; if (lat !== 5) begin bad++; $display("FAIL midreset_restart_latency got=%0d want=5", lat); end
    total++; if (o6 !== e6) begin bad++; $display("FAIL midreset_restart_out got=%h want=%h", o6, e6); end
    total++; if (o4 !== e4) begin bad++; $display("FAIL midreset_restart_out_s got=%h want=%h", o4, e4); end
  endtask

  initial begin
    rst_n = 1'b0; sample_tick = 1'b0;
    chl_in = '0; freq_in = '0; gain_in = '0;
    model_reset();
    test_reset();
    test_key_on();
    test_release();
    test_full_scale();
    test_random();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
